mux_4ch_rr_scheduler: RTL and testbench
=======================================

// Module: mux_4ch_rr_scheduler
// PURPOSE
//  Upstream control stage for the 4:1 gate-level mux: arbitrates four requesting channels
//  round-robin and drives the mux select pair (s0,s1) plus registered data bits a,b,c,d.
//  Each grant is held for HOLD_CYCLES and closed with a one-cycle ack to the winner.
//  Grants are non-preemptive. Back-to-back grants have no idle bubble.
// PARAMETERS
//  HOLD_CYCLES  1  cycles each grant is held; legal range 1..2**CNT_W; 0 is an elaboration error
//  CNT_W        4  width of hold counter
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  req        in   4  level request per channel; bit i = channel i
//  data_in    in   4  channel data bits; bit0->a, bit1->b, bit2->c, bit3->d
//  s0         out  1  mux select MSB (= granted index bit1)
//  s1         out  1  mux select LSB (= granted index bit0)
//  a,b,c,d    out  1  registered snapshot of data_in[0..3]
//  grant      out  4  one-hot granted channel; 0 when idle
//  sel_valid  out  1  high while s0/s1 and a..d are a valid grant
//  ack        out  4  one-cycle pulse on the granted bit during the final hold cycle
// BEHAVIOUR
//  - Index-to-select map (fixed): ch0 (s0,s1)=(0,0) ->a; ch1 (0,1) ->b; ch2 (1,0) ->c; ch3 (1,1) ->d.
//  - Reset (rst=1 at edge): state=IDLE; s0=s1=0; a..d=0; grant=0; sel_valid=0; ack=0;
//    last_ptr=3, so ch0 has first priority. Reset overrides everything, including a grant in progress.
//  - States:
//    - IDLE: sel_valid=0, grant=0.
//      - If |req at an edge: pick a winner; enter HOLD; grant=onehot(win); s0/s1 from win;
//        latch all four data_in bits into a..d; hold_cnt=HOLD_CYCLES-1.
//    - HOLD: sel_valid=1; grant, s0, s1 and a..d stay constant.
//      - If hold_cnt!=0: decrement hold_cnt.
//      - If hold_cnt==0 (final cycle): ack=grant in this cycle (decoded from registered state only).
//        At the next edge: last_ptr=win.
//        - If |req: grant the next winner immediately (stay in HOLD, re-latch data, reload hold_cnt).
//        - Else: go to IDLE.
//  - Round-robin search order: last_ptr+1, +2, +3, +0 (mod 4, wraps 3->0).
//    The previous winner is eligible again only if it is the sole requester.
//  - Req sampled only at grant decisions. A req drop mid-hold does not shorten the grant and ack is still issued.
//  - Latency: req rises in IDLE at cycle N -> grant/sel_valid/s0/s1 valid at N+1.
//    For a winner granted at cycle N, ack occurs at N+HOLD_CYCLES-1.
//  - HOLD_CYCLES=1: every HOLD cycle is a final cycle, so ack is high on every granted cycle.
//  - data_in changes during HOLD do not affect a..d until the next grant.
//  - Reset mid-hold: no ack is issued; all outputs are 0 on the following cycle.
// STRUCTURE
//  - Package mux4_pkg: state encoding (IDLE, HOLD), CH_W=2, NCH=4, function idx_to_sel(idx) -> {s0,s1}.
//  - Sub-module rr_pick4: combinational rotate-priority pick (req[3:0], last_ptr[1:0] -> win[1:0], any).
//  - Top-level: FSM, hold counter, last_ptr, output registers. The existing 4:1 mux connects directly to s0,s1,a..d.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=4'b1111 -> all outputs 0.
//     After release, the next cycle shows grant=0001, (s0,s1)=(0,0), sel_valid=1.
//  2. HOLD_CYCLES=1, req=1111 held -> grants 0,1,2,3,0 on consecutive cycles.
//     (s0,s1) = 00,01,10,11,00; ack equals grant every cycle; sel_valid never drops.
//  3. Sparse req=4'b1010 after a ch0 grant -> grant 0010, then 1000, then 0010 (wrap 3->1).
//     Channels 0 and 2 are never granted.
//  4. HOLD_CYCLES=3, req=0001 pulsed 1 cycle -> grant=0001 for 3 cycles; ack[0] only in cycle 3.
//     Then IDLE with sel_valid=0.
//  5. data_in=4'b0101 at grant, toggled to 1010 during hold -> a,b,c,d=1,0,1,0 until the next grant,
//     then they take the new snapshot.
//  6. HOLD_CYCLES=3, rst asserted in the 2nd hold cycle -> no ack pulse; all outputs 0 next cycle.
//     With req=1111, the first post-reset grant is ch0.

Source files
------------

// File: rtl/mux4_pkg.sv
// Shared types and helpers for the 4-channel round-robin mux scheduler.
package mux4_pkg;

  localparam int CH_W = 2;
  localparam int NCH  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Channel index maps straight onto the mux select pair: {s0,s1} = {idx[1],idx[0]}.
  function automatic logic [1:0] idx_to_sel(input logic [CH_W-1:0] idx);
    return {idx[1], idx[0]};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: searches last_ptr+1, +2, +3, +0 (mod 4).
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] last_ptr_i,
  output logic [CH_W-1:0] win_o,
  output logic            any_o
);

  logic [CH_W-1:0] idx;

  // Scan farthest-first so the nearest requester after last_ptr overrides;
  // the previous winner (offset 4 == 0) only survives when it is alone.
  always_comb begin
    win_o = '0;
    idx   = '0;
    any_o = |req_i;
    for (int k = NCH; k >= 1; k--) begin
      idx = last_ptr_i + CH_W'(k);
      if (req_i[idx]) win_o = idx;
    end
  end

endmodule

// File: rtl/mux_4ch_rr_scheduler.sv
// Round-robin control stage driving a 4:1 mux: select pair, data snapshot,
// one-hot grant held HOLD_CYCLES and closed with a one-cycle ack.
module mux_4ch_rr_scheduler
  import mux4_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic       s0,
  output logic       s1,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] grant,
  output logic       sel_valid,
  output logic [3:0] ack
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] last_ptr_q, last_ptr_d;
  logic [CH_W-1:0] win_q, win_d;
  logic [NCH-1:0]  data_q, data_d;

  logic [CH_W-1:0] pick_ptr, pick_win;
  logic            pick_any;
  logic            final_cyc;

  // On a back-to-back grant the winner being closed is the new last pointer,
  // so the picker sees it one cycle before last_ptr_q catches up.
  assign pick_ptr  = (state_q == ST_HOLD) ? win_q : last_ptr_q;
  assign final_cyc = (state_q == ST_HOLD) && (cnt_q == '0);

  rr_pick4 u_pick (
    .req_i      (req),
    .last_ptr_i (pick_ptr),
    .win_o      (pick_win),
    .any_o      (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ptr_d = last_ptr_q;
    win_d      = win_q;
    data_d     = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_HOLD;
          win_d   = pick_win;
          data_d  = data_in;
          cnt_d   = HOLD_RELOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          last_ptr_d = win_q;
          if (pick_any) begin
            win_d  = pick_win;
            data_d = data_in;
            cnt_d  = HOLD_RELOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_ptr_q <= CH_W'(NCH - 1);
      win_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ptr_q <= last_ptr_d;
      win_q      <= win_d;
      data_q     <= data_d;
    end
  end

  // sel_valid qualifies s0/s1/a..d/grant; there is no ready, the downstream
  // mux consumes every valid cycle and ack marks the last one of a grant.
  assign sel_valid    = (state_q == ST_HOLD);
  assign grant        = sel_valid ? (NCH'(1) << win_q) : '0;
  assign ack          = final_cyc ? grant : '0;
  assign {s0, s1}     = idx_to_sel(win_q);
  assign {d, c, b, a} = data_q;

endmodule

// File: tb/tb_mux_4ch_rr_scheduler.sv
// Bench for mux_4ch_rr_scheduler: HOLD_CYCLES=1 and =3 instances on shared
// stimulus, each checked against a grant-level reference model via a scoreboard.
module tb_mux_4ch_rr_scheduler;

  localparam int OW = 15;       // {sel_valid, grant[4], ack[4], s0, s1, d, c, b, a}
  localparam int W  = 2 * OW;   // {mask, expected}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] data_in = '0;

  logic       s0_w[2], s1_w[2], a_w[2], b_w[2], c_w[2], d_w[2], sv_w[2];
  logic [3:0] grant_w[2], ack_w[2];

  always #5 clk = ~clk;

  mux_4ch_rr_scheduler #(.HOLD_CYCLES(1), .CNT_W(4)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .s0(s0_w[0]), .s1(s1_w[0]), .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
    .grant(grant_w[0]), .sel_valid(sv_w[0]), .ack(ack_w[0])
  );

  mux_4ch_rr_scheduler #(.HOLD_CYCLES(3), .CNT_W(4)) u_h3 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .s0(s0_w[1]), .s1(s1_w[1]), .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
    .grant(grant_w[1]), .sel_valid(sv_w[1]), .ack(ack_w[1])
  );

  // ---------------- reference model ----------------
  int         hold_of[2] = '{1, 3};
  bit         m_busy[2];
  int         m_left[2];          // cycles of the current grant still to show, incl. this one
  logic [1:0] m_win[2], m_last[2];
  logic [3:0] m_data[2];
  bit         m_after_rst[2];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int  vectors = 0;
  int  miscompares = 0;
  bit  done = 1'b0;

  function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int ch;
      ch = (int'(last) + k) % 4;
      if (r[ch]) return ch[1:0];
    end
    return last;
  endfunction

  task automatic model_step(input int i, output logic [W-1:0] entry);
    logic [3:0]    g, ak;
    logic [OW-1:0] e, m;
    if (rst) begin
      m_busy[i] = 1'b0; m_left[i] = 0; m_last[i] = 2'd3;
      m_win[i] = 2'd0; m_data[i] = 4'd0; m_after_rst[i] = 1'b1;
    end else begin
      m_after_rst[i] = 1'b0;
      if (m_busy[i] && m_left[i] > 1) begin
        m_left[i] = m_left[i] - 1;
      end else begin
        if (m_busy[i]) m_last[i] = m_win[i];
        if (req != 4'd0) begin
          m_win[i]  = rr_next(req, m_last[i]);
          m_busy[i] = 1'b1;
          m_left[i] = hold_of[i];
          m_data[i] = data_in;
        end else begin
          m_busy[i] = 1'b0;
        end
      end
    end
    g  = m_busy[i] ? (4'b0001 << m_win[i]) : 4'b0000;
    ak = (m_busy[i] && m_left[i] == 1) ? g : 4'b0000;
    e  = {m_busy[i], g, ak, m_win[i][1], m_win[i][0], m_data[i]};
    // While idle the select/data pins are don't-care, except right after reset.
    m  = (m_busy[i] || m_after_rst[i]) ? {OW{1'b1}} : {{9{1'b1}}, 6'b0};
    entry = {m, e};
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input logic [3:0] q, input logic [3:0] dd);
    logic [W-1:0] e0, e1;
    rst = r; req = q; data_in = dd;
    model_step(0, e0); exp_q0.push_back(e0);
    model_step(1, e1); exp_q1.push_back(e1);
    @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  task automatic compare(input int i, input logic [W-1:0] ent);
    logic [OW-1:0] got, m, e;
    got = {sv_w[i], grant_w[i], ack_w[i], s0_w[i], s1_w[i], d_w[i], c_w[i], b_w[i], a_w[i]};
    m = ent[W-1:OW];
    e = ent[OW-1:0];
    vectors++;
    if (((got ^ e) & m) != '0) begin
      miscompares++;
      $display("FAIL hold%0d_outputs t=%0t got=%h exp=%h mask=%h", hold_of[i], $time, got, e, m);
    end
  endtask

  task automatic underflow(input int i);
    vectors++;
    miscompares++;
    $display("FAIL hold%0d_queue_underflow t=%0t got=empty exp=entry", hold_of[i], $time);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q0.size() != 0) compare(0, exp_q0.pop_front());
    else if (!done) underflow(0);
  end

  always @(posedge clk) begin
    #1;
    if (exp_q1.size() != 0) compare(1, exp_q1.pop_front());
    else if (!done) underflow(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset with all channels requesting, then round-robin under full load
    step(1'b1, 4'b1111, 4'd0);
    step(1'b1, 4'b1111, 4'd0);
    for (int n = 0; n < 5; n++) step(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
    // sparse requesters: wrap from ch3 back to ch1
    for (int n = 0; n < 6; n++) step(1'b0, 4'b1010, 4'($urandom_range(0, 15)));
    repeat (4) step(1'b0, 4'b0000, 4'd0);
    // single-cycle pulse, data toggled during the hold
    step(1'b0, 4'b0001, 4'b0101);
    for (int n = 0; n < 5; n++) step(1'b0, 4'b0000, 4'b1010);
    step(1'b0, 4'b0100, 4'b0011);
    repeat (4) step(1'b0, 4'b0000, 4'b1100);
    // reset during the second hold cycle of the long-hold instance
    step(1'b0, 4'b1111, 4'b0110);
    step(1'b0, 4'b0000, 4'b0110);
    step(1'b1, 4'b1111, 4'b0110);
    step(1'b0, 4'b1111, 4'b1001);
    repeat (4) step(1'b0, 4'b0000, 4'd0);
    // randomized traffic with rare resets
    for (int n = 0; n < 1500; n++) begin
      bit         r;
      logic [3:0] q;
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(r, q, 4'($urandom_range(0, 15)));
    end
    step(1'b0, 4'b0000, 4'd0);
    done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL queue_drain got=%0d/%0d exp=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
